// File: rtl/spikey_spi_target.sv
// SPI mode-0 target endpoint, fully in the FCLK domain: oversampled pins, DW-bit rx/tx words, MSB first.
// Optional sticky overrun detection is built when SPIKEY_SPI_TARGET_OVR_EN is defined.
module spikey_spi_target #(
    parameter int DW = 8
) (
    input  logic          FCLK,
    input  logic          RST,
    input  logic          SCK,
    input  logic          CS_N,
    input  logic          MOSI,
    output logic          MISO,
    output logic          MISO_OE,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          busy
`ifdef SPIKEY_SPI_TARGET_OVR_EN
    ,
    output logic          overrun,
    input  logic          ovr_clr
`endif
);

    localparam int CW = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    // busy is the FSM state seen from outside (1 = ACTIVE).
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    state_t state, state_nxt;

    logic [2:0]    sck_s, cs_s, mosi_s;
    logic          sck_rise, sck_fall, cs_rise, cs_fall;
    logic [CW-1:0] bit_cnt;
    logic [DW-2:0] rx_shift;
    logic [DW-1:0] tx_shift, hold;
    logic          hold_full;
    logic          sck_ok, word_done, reload;
    logic [DW-1:0] new_word;

    // Edge strobes are registered so every pin event acts on the third FCLK edge after capture;
    // the MOSI chain is three deep so it stays aligned with the SCK strobes.
    always_ff @(posedge FCLK) begin
        if (!RST) begin
            sck_s    <= '0;
            cs_s     <= '1;
            mosi_s   <= '0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            cs_rise  <= 1'b0;
            cs_fall  <= 1'b0;
        end else begin
            sck_s    <= {sck_s[1:0], SCK};
            cs_s     <= {cs_s[1:0], CS_N};
            mosi_s   <= {mosi_s[1:0], MOSI};
            sck_rise <= sck_s[1] & ~sck_s[2];
            sck_fall <= ~sck_s[1] & sck_s[2];
            cs_rise  <= cs_s[1] & ~cs_s[2];
            cs_fall  <= ~cs_s[1] & cs_s[2];
        end
    end

    always_ff @(posedge FCLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:  if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == ACTIVE);
        MISO_OE = busy;
        MISO    = busy & tx_shift[DW-1];
    end

    // SCK edges count only while ACTIVE and never alongside a CS_N edge.
    assign sck_ok    = (state == ACTIVE) && !cs_rise && !cs_fall;
    assign word_done = sck_ok && sck_rise && (bit_cnt == LAST);
    assign reload    = ((state == IDLE) && cs_fall) || (sck_ok && sck_fall && (bit_cnt == '0));
    assign new_word  = {rx_shift, mosi_s[2]};
    assign tx_ready  = !hold_full;

    // Handshakes: a transfer happens on a rising FCLK edge where valid && ready are both high;
    // valid is held until that edge, and data is stable while valid is high.
`ifdef SPIKEY_SPI_TARGET_OVR_EN
    logic ovr_set;
    assign ovr_set = word_done && rx_valid && !rx_ready;
`endif

    always_ff @(posedge FCLK) begin
        if (!RST) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            // A reload samples hold before any same-cycle write; the two never collide since
            // writes need an empty hold and reloads only consume a full one.
            if (tx_valid && !hold_full) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (reload && hold_full) begin
                hold_full <= 1'b0;
            end

            if (state == IDLE) begin
                bit_cnt  <= '0;
                tx_shift <= (cs_fall && hold_full) ? hold : '0;
            end else if (cs_rise) begin
                bit_cnt  <= '0;
                tx_shift <= '0;
                rx_shift <= '0;
            end else if (sck_ok) begin
                if (sck_rise) begin
                    rx_shift <= new_word[DW-2:0];
                    bit_cnt  <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
                end
                if (sck_fall) begin
                    if (bit_cnt == '0) tx_shift <= hold_full ? hold : '0;
                    else               tx_shift <= {tx_shift[DW-2:0], 1'b0};
                end
            end

`ifdef SPIKEY_SPI_TARGET_OVR_EN
            if (word_done && !ovr_set) begin
`else
            if (word_done) begin
`endif
                rx_data  <= new_word;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPIKEY_SPI_TARGET_OVR_EN
    always_ff @(posedge FCLK) begin
        if (!RST)         overrun <= 1'b0;
        else if (ovr_clr) overrun <= 1'b0;
        else if (ovr_set) overrun <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_spikey_spi_target.sv
// Bench for spikey_spi_target: vector table, hand-written frame sequences, and randomized
// frames scored against a word-level model of the hold register and rx stream.
module tb_spikey_spi_target;

    logic       FCLK, RST, SCK, CS_N, MOSI;
    logic       MISO, MISO_OE;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic       busy;
`ifdef SPIKEY_SPI_TARGET_OVR_EN
    logic       overrun, ovr_clr;
`endif

    int total = 0;
    int bad   = 0;
    bit mon_en = 0;
    logic [7:0] exp_q[$];

    spikey_spi_target #(.DW(8)) dut (
        .FCLK(FCLK), .RST(RST), .SCK(SCK), .CS_N(CS_N), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy)
`ifdef SPIKEY_SPI_TARGET_OVR_EN
        , .overrun(overrun), .ovr_clr(ovr_clr)
`endif
    );

    // clock / watchdog
    initial begin
        FCLK = 0;
        forever #5 FCLK = ~FCLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge FCLK);
    endtask

    // driver tasks
    task automatic tx_push(input logic [7:0] w);
        int t = 0;
        while (!tx_ready && t < 50) begin
            cyc(1);
            t++;
        end
        check("tx_push_wait", tx_ready, 1);
        tx_data  = w;
        tx_valid = 1;
        cyc(1);
        tx_valid = 0;
    endtask

    task automatic pulse_ready();
        rx_ready = 1;
        cyc(1);
        rx_ready = 0;
    endtask

    task automatic cs_low();
        CS_N = 0;
        cyc(6);
    endtask

    task automatic cs_high();
        cyc(4);
        CS_N = 1;
        cyc(6);
    endtask

    // Mode 0 master: MOSI changes while SCK is low, MISO is sampled just before each rise.
    // An optional tx write is issued during the high phase of bit 4.
    task automatic spi_word(input logic [7:0] mo, input bit do_tx, input logic [7:0] txw,
                            input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            MOSI = mo[i];
            cyc(5);
            mi[i] = MISO;
            SCK = 1;
            if (do_tx && i == 4) begin
                tx_data  = txw;
                tx_valid = 1;
                cyc(1);
                tx_valid = 0;
                cyc(4);
            end else begin
                cyc(5);
            end
            SCK = 0;
        end
    endtask

    // scoreboard: rx words consumed while the monitor is enabled
    always @(negedge FCLK) begin
        if (mon_en && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                check("rand_rx_extra", {24'h0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                check("rand_rx", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        bit         use_tx;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vec[5];
    logic [7:0] mi, mi0, mi1;
    logic [7:0] hold_m, cur_exp, mo, txw;
    bit         full_m, do_tx;
    int         nw;

    initial begin
        vec[0] = '{8'h3C, 8'hA5, 1'b1, 8'hA5, 8'h3C};
        vec[1] = '{8'h00, 8'hFF, 1'b1, 8'hFF, 8'h00};
        vec[2] = '{8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF};
        vec[3] = '{8'h81, 8'h7E, 1'b1, 8'h7E, 8'h81};
        vec[4] = '{8'h5A, 8'hC3, 1'b0, 8'h00, 8'h5A};

        RST = 0; SCK = 0; CS_N = 1; MOSI = 0;
        tx_data = 0; tx_valid = 0; rx_ready = 0;
`ifdef SPIKEY_SPI_TARGET_OVR_EN
        ovr_clr = 0;
`endif
        // reset
        cyc(3);
        check("rst_miso", MISO, 0);
        check("rst_miso_oe", MISO_OE, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
`ifdef SPIKEY_SPI_TARGET_OVR_EN
        check("rst_overrun", overrun, 0);
`endif
        RST = 1;
        cyc(3);

        // CS_N latency: busy and MISO_OE rise on the third edge after capture
        CS_N = 0;
        cyc(3);
        check("cs_lat_early", {busy, MISO_OE}, 2'b00);
        cyc(1);
        check("cs_lat_busy", {busy, MISO_OE}, 2'b11);
        cs_high();
        check("cs_idle_busy", busy, 0);

        // vector table: single-word frames
        for (int k = 0; k < 5; k++) begin
            if (vec[k].use_tx) tx_push(vec[k].tx);
            cs_low();
            spi_word(vec[k].mosi, 0, 8'h00, 8, mi);
            cyc(4);
            check($sformatf("vec%0d_miso", k), mi, vec[k].exp_miso);
            check($sformatf("vec%0d_rx_data", k), rx_data, vec[k].exp_rx);
            check($sformatf("vec%0d_rx_valid", k), rx_valid, 1);
            cs_high();
            check($sformatf("vec%0d_valid_held", k), rx_valid, 1);
            check($sformatf("vec%0d_tx_ready", k), tx_ready, 1);
            pulse_ready();
            check($sformatf("vec%0d_valid_clr", k), rx_valid, 0);
        end

        // back-to-back words in one frame, second tx written after the first reload
        tx_push(8'h11);
        cs_low();
        spi_word(8'hF0, 1, 8'h22, 8, mi0);
        cyc(4);
        check("b2b_rx0", rx_data, 8'hF0);
        check("b2b_valid0", rx_valid, 1);
        pulse_ready();
        spi_word(8'h0F, 0, 8'h00, 8, mi1);
        cyc(4);
        check("b2b_rx1", rx_data, 8'h0F);
        check("b2b_miso0", mi0, 8'h11);
        check("b2b_miso1", mi1, 8'h22);
        pulse_ready();
        cs_high();

        // underrun: nothing loaded
        cs_low();
        spi_word(8'hC6, 0, 8'h00, 8, mi);
        cyc(4);
        check("urun_miso", mi, 8'h00);
        check("urun_tx_ready", tx_ready, 1);
        check("urun_rx", rx_data, 8'hC6);
        pulse_ready();
        cs_high();

        // abort after 5 bits; the word written mid-frame is retained for the next frame
        cs_low();
        spi_word(8'hFF, 1, 8'h9C, 5, mi);
        cyc(4);
        cs_high();
        check("abort_no_valid", rx_valid, 0);
        check("abort_hold_kept", tx_ready, 0);
        check("abort_idle", busy, 0);
        cs_low();
        spi_word(8'h81, 0, 8'h00, 8, mi);
        cyc(4);
        check("abort_rx_new", rx_data, 8'h81);
        check("abort_valid_new", rx_valid, 1);
        check("abort_miso_hold", mi, 8'h9C);
        pulse_ready();
        cs_high();

        // two words with no consumer
        cs_low();
        spi_word(8'h12, 0, 8'h00, 8, mi);
        spi_word(8'h34, 0, 8'h00, 8, mi);
        cyc(4);
        check("ovr_valid", rx_valid, 1);
`ifdef SPIKEY_SPI_TARGET_OVR_EN
        check("ovr_rx_kept", rx_data, 8'h12);
        check("ovr_flag", overrun, 1);
        ovr_clr = 1;
        cyc(1);
        ovr_clr = 0;
        check("ovr_cleared", overrun, 0);
`else
        check("ovr_rx_overwrite", rx_data, 8'h34);
`endif
        pulse_ready();
        cs_high();

        // randomized frames against the word-level model
        rx_ready = 1;
        mon_en   = 1;
        full_m   = 0;
        hold_m   = 0;
        for (int f = 0; f < 8; f++) begin
            nw = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                txw = 8'($urandom);
                tx_push(txw);
                hold_m = txw;
                full_m = 1;
            end
            cs_low();
            cur_exp = full_m ? hold_m : 8'h00;
            full_m  = 0;
            for (int w = 0; w < nw; w++) begin
                mo    = 8'($urandom);
                do_tx = ($urandom_range(0, 1) == 1);
                txw   = 8'($urandom);
                exp_q.push_back(mo);
                spi_word(mo, do_tx, txw, 8, mi);
                check("rand_miso", mi, cur_exp);
                if (do_tx) begin
                    hold_m = txw;
                    full_m = 1;
                end
                cur_exp = full_m ? hold_m : 8'h00;
                full_m  = 0;
            end
            cs_high();
            check("rand_tx_ready", tx_ready, !full_m);
        end
        check("rand_rx_drained", exp_q.size(), 0);
        mon_en   = 0;
        rx_ready = 0;

        // reset mid-frame
        tx_push(8'h5A);
        cs_low();
        spi_word(8'hAA, 0, 8'h00, 3, mi);
        RST = 0;
        cyc(1);
        check("mrst_state", {MISO, MISO_OE, busy, rx_valid}, 4'b0000);
        check("mrst_tx_ready", tx_ready, 1);
        check("mrst_rx_data", rx_data, 0);
        CS_N = 1;
        SCK  = 0;
        cyc(2);
        RST = 1;
        cyc(6);
        check("mrst_after", {busy, tx_ready, rx_valid}, 3'b010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
